mc_ctrl_fsm: RTL and testbench

//  Multicycle MIPS control FSM: decodes IR opcode, sequences FETCH..WB, drives all datapath mux selects
//  (twomux32/twomux5 1-bit selects, fourmux32 2-bit selects) plus the register/memory enables.

---
 rtl/mc_ctrl_fsm.sv | 282 ++++++++++++++++++++++++++++
 tb/tb_mc_ctrl_fsm.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_ctrl_fsm.sv
// -----------------------------------------------------------------------------
// mc_ctrl_fsm -- multicycle MIPS control sequencer
//
// Decodes the IR opcode and steps each instruction through
// FETCH -> DECODE -> (MEMADR/EXEC/BRANCH/JUMP/IMMEX) -> ... -> FETCH.
// It drives every datapath mux select and the register-file, memory, IR and PC
// enables. Outputs are Moore, decoded from the state register. The one
// exception is FETCH: ir_write and pc_write are qualified by mem_ready, so the
// IR and PC load only in the cycle the instruction word actually arrives.
//
// Optional feature (compile-time macro MC_CTRL_ILLEGAL_TRAP_EN):
//   defined   : an unknown opcode in DECODE enters TRAP. TRAP holds until reset,
//               keeps all enables low and sets the sticky illegal_op flag.
//   undefined : an unknown opcode is treated as a NOP (back to FETCH), and
//               illegal_op is tied low.
//
// Ports
//   clk            in   rising-edge clock
//   rst_n          in   asynchronous active-low reset
//   opcode[5:0]    in   IR[31:26]; only looked at in DECODE
//   mem_ready      in   memory completes the current read/write this cycle
//   pc_write       out  unconditional PC load
//   pc_write_cond  out  PC load when the ALU zero flag is set (BEQ)
//   iord           out  memory address mux: 0 = PC, 1 = ALUOut
//   mem_read       out  memory read request
//   mem_write      out  memory write request
//   ir_write       out  IR load
//   reg_dst        out  write-register mux: 0 = rt, 1 = rd
//   mem_to_reg     out  write-data mux: 0 = ALUOut, 1 = MDR
//   reg_write      out  register file write enable
//   alu_src_a      out  0 = PC, 1 = A
//   alu_src_b[1:0] out  00 = B, 01 = 4, 10 = sext imm, 11 = sext imm << 2
//   alu_op[1:0]    out  00 = add, 01 = sub, 10 = use funct field
//   pc_src[1:0]    out  00 = ALU result, 01 = ALUOut, 10 = jump target
//   state_o[3:0]   out  current state encoding (debug)
//   illegal_op     out  sticky illegal-opcode flag
// -----------------------------------------------------------------------------
module mc_ctrl_fsm #(
  parameter logic [5:0] OP_RTYPE = 6'h00,
  parameter logic [5:0] OP_LW    = 6'h23,
  parameter logic [5:0] OP_SW    = 6'h2B,
  parameter logic [5:0] OP_BEQ   = 6'h04,
  parameter logic [5:0] OP_J     = 6'h02,
  parameter logic [5:0] OP_ADDI  = 6'h08
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_src,
  output logic [3:0] state_o,
  output logic       illegal_op
);

  // Encodings are visible on state_o, so they are fixed explicitly.
  // Codes 14 and 15 are unused and recover to FETCH.
  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,
    S_MEMWB  = 4'd5,
    S_MEMWR  = 4'd6,
    S_EXEC   = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9,
    S_JUMP   = 4'd10,
    S_IMMEX  = 4'd11,
    S_IMMWB  = 4'd12,
    S_TRAP   = 4'd13
  } state_e;

  state_e state_q, state_d;

  // Opcode is only sampled in DECODE; MEMADR needs to know load vs store one
  // cycle later, so that single decision is captured here.
  logic is_lw_q, is_lw_d;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge value of its _d input regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      is_lw_q <= 1'b0;
    end else begin
      state_q <= state_d;
      is_lw_q <= is_lw_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every variable assigned in an always_comb gets a default at the top;
  // a path that skips an assignment would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    is_lw_d = is_lw_q;

    case (state_q)
      S_IDLE:   state_d = S_FETCH;

      S_FETCH:  if (mem_ready) state_d = S_DECODE;

      S_DECODE: begin
        is_lw_d = (opcode == OP_LW);
        case (opcode)
          OP_LW,
          OP_SW:    state_d = S_MEMADR;
          OP_RTYPE: state_d = S_EXEC;
          OP_BEQ:   state_d = S_BRANCH;
          OP_J:     state_d = S_JUMP;
          OP_ADDI:  state_d = S_IMMEX;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
          default:  state_d = S_TRAP;
`else
          default:  state_d = S_FETCH;   // unknown opcode retires as a NOP
`endif
        endcase
      end

      S_MEMADR: state_d = is_lw_q ? S_MEMRD : S_MEMWR;

      S_MEMRD:  if (mem_ready) state_d = S_MEMWB;
      S_MEMWB:  state_d = S_FETCH;

      S_MEMWR:  if (mem_ready) state_d = S_FETCH;

      S_EXEC:   state_d = S_ALUWB;
      S_ALUWB:  state_d = S_FETCH;

      S_BRANCH: state_d = S_FETCH;
      S_JUMP:   state_d = S_FETCH;

      S_IMMEX:  state_d = S_IMMWB;
      S_IMMWB:  state_d = S_FETCH;

`ifdef MC_CTRL_ILLEGAL_TRAP_EN
      S_TRAP:   state_d = S_TRAP;        // only reset leaves TRAP
`else
      S_TRAP:   state_d = S_FETCH;       // unreachable without the trap feature
`endif

      default:  state_d = S_FETCH;       // codes 14/15
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output decode
  // ---------------------------------------------------------------------------
  // Everything defaults to 0, so IDLE, TRAP and the unused codes drive no
  // enables. Since the state resets asynchronously, every enable drops in the
  // same cycle rst_n falls, even in the middle of an instruction.
  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    pc_src        = 2'b00;

    case (state_q)
      S_FETCH: begin
        // PC + 4 is computed every FETCH cycle. The IR and PC load only when
        // the instruction word arrives, so a wait cycle repeats the same
        // fetch harmlessly.
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end

      S_DECODE: begin
        // Branch target PC + (imm << 2) is computed speculatively into ALUOut.
        alu_src_b = 2'b11;
      end

      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end

      S_MEMRD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
      end

      S_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end

      S_MEMWR: begin
        // Held steady for the whole wait; the write completes on mem_ready.
        mem_write = 1'b1;
        iord      = 1'b1;
      end

      S_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
      end

      S_ALUWB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end

      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = 2'b01;
        pc_write_cond = 1'b1;
        pc_src        = 2'b01;
      end

      S_JUMP: begin
        pc_write = 1'b1;
        pc_src   = 2'b10;
      end

      S_IMMEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end

      S_IMMWB: begin
        reg_write = 1'b1;
      end

      default: ;  // IDLE, TRAP, unused codes: all outputs stay 0
    endcase
  end

  assign state_o = state_q;

  // ---------------------------------------------------------------------------
  // Sticky illegal-opcode flag
  // ---------------------------------------------------------------------------
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
  logic illegal_q, illegal_d;

  // The flag is set on the DECODE -> TRAP transition, so it is already high
  // in the first TRAP cycle.
  always_comb begin
    illegal_d = illegal_q;
    if (state_q == S_DECODE && state_d == S_TRAP) illegal_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) illegal_q <= 1'b0;
    else        illegal_q <= illegal_d;
  end

  assign illegal_op = illegal_q;
`else
  assign illegal_op = 1'b0;
`endif

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// -----------------------------------------------------------------------------
// tb_mc_ctrl_fsm -- self-checking bench for mc_ctrl_fsm
//
// For every cycle, the bench computes the expected state and the full output
// vector from its own table of per-state control values. It pushes that
// expectation onto a scoreboard queue and pops it once the DUT has settled
// for that cycle. Inputs change 1 ns after the rising edge, and outputs are
// compared 1 ns later.
// -----------------------------------------------------------------------------
module tb_mc_ctrl_fsm;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_BAD   = 6'h3F;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] opcode = 6'h00;
  logic       mem_ready = 1'b0;
  logic       pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
  logic       reg_dst, mem_to_reg, reg_write, alu_src_a, illegal_op;
  logic [1:0] alu_src_b, alu_op, pc_src;
  logic [3:0] state_o;

  mc_ctrl_fsm dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .opcode        (opcode),
    .mem_ready     (mem_ready),
    .pc_write      (pc_write),
    .pc_write_cond (pc_write_cond),
    .iord          (iord),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .ir_write      (ir_write),
    .reg_dst       (reg_dst),
    .mem_to_reg    (mem_to_reg),
    .reg_write     (reg_write),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .alu_op        (alu_op),
    .pc_src        (pc_src),
    .state_o       (state_o),
    .illegal_op    (illegal_op)
  );

  always #5 clk = ~clk;

  // Output vector layout:
  // {pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
  //  reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op, pc_src,
  //  illegal_op}
  logic [16:0] act;
  assign act = {pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
                reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op,
                pc_src, illegal_op};

  typedef struct packed {
    logic [3:0]  st;
    logic [16:0] outs;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  logic ill_exp = 1'b0;

`ifdef MC_CTRL_ILLEGAL_TRAP_EN
  localparam bit TRAP_ON = 1'b1;
`else
  localparam bit TRAP_ON = 1'b0;
`endif

  // Expected control outputs, taken from the state-by-state control table.
  function automatic logic [16:0] model(input logic [3:0] st, input logic mr,
                                        input logic ill);
    logic pcw, pcwc, io, mrd, mwr, irw, rdst, m2r, rw, asa;
    logic [1:0] asb, aop, psrc;
    {pcw, pcwc, io, mrd, mwr, irw, rdst, m2r, rw, asa} = '0;
    asb = 2'b00; aop = 2'b00; psrc = 2'b00;
    case (st)
      4'd1:  begin mrd = 1'b1; asb = 2'b01; irw = mr; pcw = mr; end
      4'd2:  asb = 2'b11;
      4'd3:  begin asa = 1'b1; asb = 2'b10; end
      4'd4:  begin mrd = 1'b1; io = 1'b1; end
      4'd5:  begin rw = 1'b1; m2r = 1'b1; end
      4'd6:  begin mwr = 1'b1; io = 1'b1; end
      4'd7:  begin asa = 1'b1; aop = 2'b10; end
      4'd8:  begin rw = 1'b1; rdst = 1'b1; end
      4'd9:  begin asa = 1'b1; aop = 2'b01; pcwc = 1'b1; psrc = 2'b01; end
      4'd10: begin pcw = 1'b1; psrc = 2'b10; end
      4'd11: begin asa = 1'b1; asb = 2'b10; end
      4'd12: rw = 1'b1;
      default: ;
    endcase
    return {pcw, pcwc, io, mrd, mwr, irw, rdst, m2r, rw, asa, asb, aop, psrc, ill};
  endfunction

  // Drive one cycle of stimulus, queue the expectation, compare once the
  // outputs have settled, then advance to 1 ns after the next rising edge.
  task automatic step(input logic mr, input logic [5:0] op,
                      input logic [3:0] exp_st, input string nm);
    exp_t e;
    exp_t got;
    mem_ready = mr;
    opcode    = op;
    e.st   = exp_st;
    e.outs = model(exp_st, mr, ill_exp);
    sb.push_back(e);
    #1;
    got = sb.pop_front();
    total++;
    if (state_o !== got.st) begin
      bad++;
      $display("FAIL %s state_o: got %0d want %0d", nm, state_o, got.st);
    end
    total++;
    if (act !== got.outs) begin
      bad++;
      $display("FAIL %s outputs: got %b want %b", nm, act, got.outs);
    end
    total++;
    if (mem_read && mem_write) begin
      bad++;
      $display("FAIL %s rd_wr_excl: got mem_read=1 mem_write=1 want not both", nm);
    end
    total++;
    if (reg_write && pc_write) begin
      bad++;
      $display("FAIL %s rw_pcw_excl: got reg_write=1 pc_write=1 want not both", nm);
    end
    @(posedge clk);
    #1;
  endtask

  // Check that all outputs are zero and the state is IDLE while reset is held.
  task automatic check_reset_zero(input string nm);
    total++;
    if (state_o !== 4'd0) begin
      bad++;
      $display("FAIL %s state_o: got %0d want 0", nm, state_o);
    end
    total++;
    if (act !== 17'd0) begin
      bad++;
      $display("FAIL %s outputs: got %b want all zero", nm, act);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    check_reset_zero("reset_hold");
    @(posedge clk); #1;
    rst_n = 1'b1;
    step(1'b1, OP_LW, 4'd0, "reset_idle");   // leaves the DUT entering FETCH
  endtask

  task automatic test_lw();
    step(1'b1, OP_LW, 4'd1, "lw_fetch");
    step(1'b1, OP_LW, 4'd2, "lw_decode");
    step(1'b1, OP_LW, 4'd3, "lw_memadr");
    step(1'b1, OP_LW, 4'd4, "lw_memrd");
    step(1'b1, OP_LW, 4'd5, "lw_memwb");
  endtask

  task automatic test_sw_wait();
    step(1'b1, OP_SW, 4'd1, "sw_fetch");
    step(1'b1, OP_SW, 4'd2, "sw_decode");
    step(1'b1, OP_SW, 4'd3, "sw_memadr");
    for (int i = 0; i < 3; i++)
      step(1'b0, OP_SW, 4'd6, $sformatf("sw_memwr_wait%0d", i));
    step(1'b1, OP_SW, 4'd6, "sw_memwr_done");
  endtask

  task automatic test_branch_jump();
    step(1'b1, OP_BEQ, 4'd1, "beq_fetch");
    step(1'b1, OP_BEQ, 4'd2, "beq_decode");
    step(1'b1, OP_BEQ, 4'd9, "beq_branch");
    step(1'b1, OP_J,   4'd1, "j_fetch");
    step(1'b1, OP_J,   4'd2, "j_decode");
    step(1'b1, OP_J,   4'd10, "j_jump");
  endtask

  task automatic test_fetch_wait_rtype();
    step(1'b0, OP_RTYPE, 4'd1, "rt_fetch_wait0");
    step(1'b0, OP_RTYPE, 4'd1, "rt_fetch_wait1");
    step(1'b1, OP_RTYPE, 4'd1, "rt_fetch_ready");
    step(1'b1, OP_RTYPE, 4'd2, "rt_decode");
    step(1'b1, OP_RTYPE, 4'd7, "rt_exec");
    step(1'b1, OP_RTYPE, 4'd8, "rt_aluwb");
  endtask

  task automatic test_addi();
    step(1'b1, OP_ADDI, 4'd1, "addi_fetch");
    step(1'b1, OP_ADDI, 4'd2, "addi_decode");
    step(1'b1, OP_ADDI, 4'd11, "addi_immex");
    step(1'b1, OP_ADDI, 4'd12, "addi_immwb");
  endtask

  // Load stalled in MEMRD, then reset is asserted asynchronously mid-cycle.
  task automatic test_reset_mid_memrd();
    step(1'b1, OP_LW, 4'd1, "rstmid_fetch");
    step(1'b1, OP_LW, 4'd2, "rstmid_decode");
    step(1'b1, OP_LW, 4'd3, "rstmid_memadr");
    step(1'b0, OP_LW, 4'd4, "rstmid_memrd_wait");
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_zero("rstmid_async");
    @(posedge clk); #1;
    check_reset_zero("rstmid_held");
    rst_n = 1'b1;
    step(1'b1, OP_LW, 4'd0, "rstmid_idle");
  endtask

  task automatic test_illegal();
    step(1'b1, OP_BAD, 4'd1, "ill_fetch");
    step(1'b1, OP_BAD, 4'd2, "ill_decode");
    if (TRAP_ON) begin
      ill_exp = 1'b1;
      for (int i = 0; i < 3; i++)
        step(1'b1, OP_RTYPE, 4'd13, $sformatf("ill_trap%0d", i));
    end else begin
      step(1'b1, OP_BAD, 4'd1, "ill_nop_fetch");
    end
    rst_n = 1'b0;
    ill_exp = 1'b0;
    #1;
    check_reset_zero("ill_reset_clears");
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_lw();
    test_sw_wait();
    test_branch_jump();
    test_fetch_wait_rtype();
    test_addi();
    test_reset_mid_memrd();
    test_illegal();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
